// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode and datapath mux encodings shared by the sequencer and datapath
package mc_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] A_PC      = 2'b00;
  localparam logic [1:0] A_RS1     = 2'b01;
  localparam logic [1:0] A_OLDPC   = 2'b10;
  localparam logic [1:0] B_RS2     = 2'b00;
  localparam logic [1:0] B_FOUR    = 2'b01;
  localparam logic [1:0] B_IMM     = 2'b10;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;
  typedef struct packed {
    logic r;
    logic i;
    logic ld;
    logic st;
    logic br;
    logic jal;
  } op_class_t;
endpackage

// File: rtl/mc_opcode_decode.sv
// mc_opcode_decode: maps IR[6:0] to a one-hot instruction class plus a legal bit
//   i_opcode  in   IR[6:0]
//   o_cls     out  one-hot {r, i, ld, st, br, jal}
//   o_legal   out  opcode belongs to a supported class
module mc_opcode_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output op_class_t  o_cls,
  output logic       o_legal
);
  assign o_cls = '{
    r:   i_opcode == OP_R,
    i:   i_opcode == OP_I,
    ld:  i_opcode == OP_LD,
    st:  i_opcode == OP_ST,
    br:  i_opcode == OP_BR,
    jal: i_opcode == OP_JAL
  };
  assign o_legal = |o_cls;
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multi-cycle RV32 sequencer driving datapath strobes and mux selects
//   clk, rst_n            clock, async active-low reset
//   run                   execute enable, honoured at instruction boundaries
//   opcode, zero          IR[6:0] and ALU zero flag
//   mem_ready             memory completes the current access this cycle
//   pc_write..wb_sel      datapath strobes and mux selects (encodings in mc_ctrl_pkg)
//   state, illegal        debug state, sticky illegal-opcode flag
//   retired_cnt           retired-instruction counter (wraps)
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt
);
  state_t     r_state, w_next;
  op_class_t  w_cls;
  logic       w_legal, w_retire, r_illegal;
  logic [CNT_W-1:0] r_cnt;
  mc_opcode_decode u_dec (
    .i_opcode (opcode),
    .o_cls    (w_cls),
    .o_legal  (w_legal)
  );
  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    ir_write  = 1'b0;
    iord      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    alu_src_a = A_PC;
    alu_src_b = B_RS2;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    case (r_state)
      S_IDLE: w_next = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = B_FOUR;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        w_next    = w_legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        if (w_cls.r) begin
          alu_src_a = A_RS1;
          alu_op    = ALU_FUNCT;
          w_next    = S_WB;
        end else if (w_cls.i) begin
          alu_src_a = A_RS1;
          alu_src_b = B_IMM;
          alu_op    = ALU_FUNCT;
          w_next    = S_WB;
        end else if (w_cls.ld || w_cls.st) begin
          alu_src_a = A_RS1;
          alu_src_b = B_IMM;
          w_next    = S_MEM;
        end else if (w_cls.br) begin
          alu_src_a = A_RS1;
          alu_op    = ALU_SUB;
          pc_write  = zero;
          pc_src    = 1'b1;
          w_retire  = 1'b1;
        end else if (w_cls.jal) begin
          pc_write  = 1'b1;
          pc_src    = 1'b1;
          reg_write = 1'b1;
          wb_sel    = WB_PC;
          w_retire  = 1'b1;
        end else begin
          w_next = S_HALT;
        end
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = w_cls.ld;
        mem_write = w_cls.st;
        if (mem_ready) begin
          w_next   = w_cls.ld ? S_WB : r_state;
          w_retire = !w_cls.ld;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = w_cls.ld ? WB_MDR : WB_ALU;
        w_retire  = 1'b1;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
    // a retiring instruction parks in IDLE instead of fetching when run drops
    if (w_retire) w_next = run ? S_FETCH : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_HALT) r_illegal <= 1'b1;
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  assign state       = r_state;
  assign illegal     = r_illegal;
  assign retired_cnt = r_cnt;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: table-driven and sequence checks of the multi-cycle sequencer
module tb_multicycle_ctrl_fsm;
  import mc_ctrl_pkg::*;
  localparam int CW = 4;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [2:0] state;
  logic [CW-1:0] retired_cnt;
  logic [17:0] w_act;
  int total = 0, bad = 0;
  typedef struct {
    logic        run;
    logic [6:0]  op;
    logic        z;
    logic        mr;
    logic [17:0] exp;
  } vec_t;
  vec_t q[$];
  multicycle_ctrl_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .wb_sel(wb_sel), .state(state),
    .illegal(illegal), .retired_cnt(retired_cnt)
  );
  always #5 clk = ~clk;
  assign w_act = {state, pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                  reg_write, alu_src_a, alu_src_b, alu_op, wb_sel};
  function automatic vec_t v(input logic r, input logic [6:0] op, input logic z, input logic mr,
                             input logic [2:0] st, input logic [6:0] sb,
                             input logic [1:0] a, input logic [1:0] b,
                             input logic [1:0] o, input logic [1:0] w);
    vec_t t;
    t.run = r;
    t.op  = op;
    t.z   = z;
    t.mr  = mr;
    t.exp = {st, sb, a, b, o, w};
    return t;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    q.push_back(v(1, OP_R,   0, 1, 3'd0, 7'b0000000, 0, 0, 0, 0));
    q.push_back(v(1, OP_R,   0, 1, 3'd1, 7'b1010100, 0, 1, 0, 0));
    q.push_back(v(1, OP_R,   0, 1, 3'd2, 7'b0000000, 2, 2, 0, 0));
    q.push_back(v(1, OP_R,   0, 1, 3'd3, 7'b0000000, 1, 0, 2, 0));
    q.push_back(v(1, OP_R,   0, 1, 3'd5, 7'b0000001, 0, 0, 0, 0));
    q.push_back(v(1, OP_I,   0, 1, 3'd1, 7'b1010100, 0, 1, 0, 0));
    q.push_back(v(1, OP_I,   0, 1, 3'd2, 7'b0000000, 2, 2, 0, 0));
    q.push_back(v(1, OP_I,   0, 1, 3'd3, 7'b0000000, 1, 2, 2, 0));
    q.push_back(v(1, OP_I,   0, 1, 3'd5, 7'b0000001, 0, 0, 0, 0));
    q.push_back(v(1, OP_LD,  0, 1, 3'd1, 7'b1010100, 0, 1, 0, 0));
    q.push_back(v(1, OP_LD,  0, 1, 3'd2, 7'b0000000, 2, 2, 0, 0));
    q.push_back(v(1, OP_LD,  0, 1, 3'd3, 7'b0000000, 1, 2, 0, 0));
    q.push_back(v(1, OP_LD,  0, 0, 3'd4, 7'b0001100, 0, 0, 0, 0));
    q.push_back(v(1, OP_LD,  0, 0, 3'd4, 7'b0001100, 0, 0, 0, 0));
    q.push_back(v(1, OP_LD,  0, 0, 3'd4, 7'b0001100, 0, 0, 0, 0));
    q.push_back(v(1, OP_LD,  0, 1, 3'd4, 7'b0001100, 0, 0, 0, 0));
    q.push_back(v(1, OP_LD,  0, 1, 3'd5, 7'b0000001, 0, 0, 0, 1));
    q.push_back(v(1, OP_ST,  0, 1, 3'd1, 7'b1010100, 0, 1, 0, 0));
    q.push_back(v(1, OP_ST,  0, 1, 3'd2, 7'b0000000, 2, 2, 0, 0));
    q.push_back(v(1, OP_ST,  0, 1, 3'd3, 7'b0000000, 1, 2, 0, 0));
    q.push_back(v(1, OP_ST,  0, 1, 3'd4, 7'b0001010, 0, 0, 0, 0));
    q.push_back(v(1, OP_BR,  1, 1, 3'd1, 7'b1010100, 0, 1, 0, 0));
    q.push_back(v(1, OP_BR,  1, 1, 3'd2, 7'b0000000, 2, 2, 0, 0));
    q.push_back(v(1, OP_BR,  1, 1, 3'd3, 7'b1100000, 1, 0, 1, 0));
    q.push_back(v(1, OP_BR,  0, 1, 3'd1, 7'b1010100, 0, 1, 0, 0));
    q.push_back(v(1, OP_BR,  0, 1, 3'd2, 7'b0000000, 2, 2, 0, 0));
    q.push_back(v(1, OP_BR,  0, 1, 3'd3, 7'b0100000, 1, 0, 1, 0));
    q.push_back(v(1, OP_JAL, 0, 0, 3'd1, 7'b0000100, 0, 0, 0, 0));
    q.push_back(v(1, OP_JAL, 0, 1, 3'd1, 7'b1010100, 0, 1, 0, 0));
    q.push_back(v(1, OP_JAL, 0, 1, 3'd2, 7'b0000000, 2, 2, 0, 0));
    q.push_back(v(0, OP_JAL, 0, 1, 3'd3, 7'b1100001, 0, 0, 0, 2));
    q.push_back(v(0, OP_JAL, 0, 1, 3'd0, 7'b0000000, 0, 0, 0, 0));
    q.push_back(v(0, OP_R,   0, 1, 3'd0, 7'b0000000, 0, 0, 0, 0));
    #2;
    chk("reset_outputs", {14'd0, w_act}, 32'd0);
    chk("reset_cnt", {28'd0, retired_cnt}, 32'd0);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < q.size(); k++) begin
      run = q[k].run;
      opcode = q[k].op;
      zero = q[k].z;
      mem_ready = q[k].mr;
      #1;
      chk($sformatf("vec%0d", k), {14'd0, w_act}, {14'd0, q[k].exp});
      tick();
    end
    chk("table_cnt", {28'd0, retired_cnt}, 32'd7);
    chk("table_illegal", {31'd0, illegal}, 32'd0);
    // async reset while a store is waiting in MEM
    run = 1'b1;
    opcode = OP_ST;
    mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    tick();
    chk("mid_mem_write", {31'd0, mem_write}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {14'd0, w_act}, 32'd0);
    chk("abort_cnt", {28'd0, retired_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    // illegal opcode halts for good
    opcode = 7'h7F;
    mem_ready = 1'b1;
    repeat (3) tick();
    chk("halt_state", {29'd0, state}, 32'd6);
    chk("halt_illegal", {31'd0, illegal}, 32'd1);
    for (int k = 0; k < 100; k++) begin
      run = 1'($urandom_range(1));
      zero = 1'($urandom_range(1));
      mem_ready = 1'($urandom_range(1));
      opcode = (k % 2 == 0) ? OP_R : OP_BR;
      #1;
      chk($sformatf("halt%0d", k), {14'd0, w_act, retired_cnt, illegal},
          {14'd0, 3'd6, 15'd0, 4'd0, 1'b1});
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("illegal_cleared", {31'd0, illegal}, 32'd0);
    tick();
    rst_n = 1'b1;
    // counter wrap and run=0 parking
    run = 1'b1;
    zero = 1'b0;
    mem_ready = 1'b1;
    opcode = OP_BR;
    tick();
    repeat (15) repeat (3) tick();
    chk("cnt_full", {28'd0, retired_cnt}, 32'd15);
    chk("cnt_full_state", {29'd0, state}, 32'd1);
    opcode = OP_R;
    repeat (3) tick();
    chk("wrap_wb_state", {29'd0, state}, 32'd5);
    run = 1'b0;
    tick();
    chk("park_idle", {29'd0, state}, 32'd0);
    chk("cnt_wrap", {28'd0, retired_cnt}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
